// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues in-order imem requests and queues responses for IF/ID.
// Optional performance counters are compiled in when FETCH_PERF_CNT_EN is defined.
module fetch_unit #(
   parameter logic [63:0] RESET_PC        = 64'h0,
   parameter int          DEPTH           = 4,
   parameter int          MAX_OUTSTANDING = 2,
   parameter logic [31:0] NOP_INSTR       = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall_F,
   input  logic        redirect_E,
   input  logic [63:0] redirect_pc_E,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [63:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic [63:0] PC_F,
   output logic [31:0] Instr_F,
   output logic        valid_F
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [63:0] perf_fetched,
   output logic [63:0] perf_redirects,
   output logic [31:0] perf_dropped
`endif
);

   localparam int QAW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int PAW   = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

   // Handshake: a request transfers on a rising edge where imem_req_valid && imem_req_ready;
   // imem_req_addr is stable while valid waits for ready. Responses return in request order
   // and have no backpressure; a response is only meaningful while a request is outstanding.

   logic [63:0]      pc_q;
   logic [63:0]      q_pc    [DEPTH];
   logic [31:0]      q_instr [DEPTH];
   logic [QAW-1:0]   rd_ptr;
   logic [QAW-1:0]   wr_ptr;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] outstanding;
   logic [CNT_W-1:0] drop_cnt;
   logic [63:0]      pf_mem [MAX_OUTSTANDING];
   logic [PAW-1:0]   pf_rd;
   logic [PAW-1:0]   pf_wr;

   logic             req_fire;
   logic             rsp_fire;
   logic             rsp_drop;
   logic             push;
   logic             pop;
   logic [CNT_W:0]   credit_used;
   logic [CNT_W-1:0] outstanding_nxt;

   function automatic logic [PAW-1:0] pf_next(input logic [PAW-1:0] p);
      if (p == PAW'(MAX_OUTSTANDING - 1)) begin
         return '0;
      end
      return p + PAW'(1);
   endfunction

   // Credits cover both queued and in-flight instructions, so a response always finds a free slot.
   always_comb begin
      credit_used     = {1'b0, count} + {1'b0, outstanding};
      imem_req_valid  = rst_n && !redirect_E && (drop_cnt == '0)
                        && (outstanding < CNT_W'(MAX_OUTSTANDING))
                        && (credit_used < (CNT_W + 1)'(DEPTH));
      imem_req_addr   = pc_q;
      req_fire        = imem_req_valid && imem_req_ready;
      rsp_fire        = imem_rsp_valid && (outstanding != '0);
      rsp_drop        = rsp_fire && (redirect_E || (drop_cnt != '0));
      push            = rsp_fire && !rsp_drop;
      valid_F         = (count != '0);
      pop             = valid_F && !stall_F;
      outstanding_nxt = outstanding + CNT_W'(req_fire) - CNT_W'(rsp_fire);
      PC_F            = '0;
      Instr_F         = NOP_INSTR;
      if (valid_F) begin
         PC_F    = q_pc[rd_ptr];
         Instr_F = q_instr[rd_ptr];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q        <= RESET_PC;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
         outstanding <= '0;
         drop_cnt    <= '0;
         pf_rd       <= '0;
         pf_wr       <= '0;
      end else begin
         outstanding <= outstanding_nxt;
         if (req_fire) begin
            pf_wr <= pf_next(pf_wr);
         end
         if (rsp_fire) begin
            pf_rd <= pf_next(pf_rd);
         end
         if (redirect_E) begin
            // Everything still in flight belongs to the wrong path; a response this cycle is already dropped.
            pc_q     <= {redirect_pc_E[63:2], 2'b00};
            drop_cnt <= outstanding - CNT_W'(rsp_fire);
            count    <= '0;
            rd_ptr   <= wr_ptr;
         end else begin
            if (req_fire) begin
               pc_q <= pc_q + 64'd4;
            end
            if (rsp_drop) begin
               drop_cnt <= drop_cnt - CNT_W'(1);
            end
            if (push) begin
               wr_ptr <= wr_ptr + QAW'(1);
            end
            if (pop) begin
               rd_ptr <= rd_ptr + QAW'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
         end
      end
   end

   // Payload storage needs no reset: every read is qualified by count or outstanding.
   always_ff @(posedge clk) begin
      if (req_fire) begin
         pf_mem[pf_wr] <= pc_q;
      end
      if (push) begin
         q_pc[wr_ptr]    <= pf_mem[pf_rd];
         q_instr[wr_ptr] <= imem_rsp_data;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_fetched   <= '0;
         perf_redirects <= '0;
         perf_dropped   <= '0;
      end else begin
         if (pop) begin
            perf_fetched <= perf_fetched + 64'd1;
         end
         if (redirect_E) begin
            perf_redirects <= perf_redirects + 64'd1;
         end
         if (rsp_drop) begin
            perf_dropped <= perf_dropped + 32'd1;
         end
      end
   end
`endif

   a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
      push |-> (count < CNT_W'(DEPTH)));
   a_outstanding_bound: assert property (@(posedge clk) disable iff (!rst_n)
      outstanding <= CNT_W'(MAX_OUTSTANDING));

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: in-order imem model, expected-PC scoreboard and output monitor.
module tb_fetch_unit;

   localparam logic [63:0] RESET_PC  = 64'h0;
   localparam int          DEPTH     = 4;
   localparam int          MAX_OUT   = 2;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall_F = 1'b0;
   logic        redirect_E = 1'b0;
   logic [63:0] redirect_pc_E = '0;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [63:0] imem_req_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = '0;
   logic [63:0] PC_F;
   logic [31:0] Instr_F;
   logic        valid_F;

   typedef struct packed {
      logic [31:0] epoch;
      logic [63:0] addr;
   } pend_t;

   pend_t       pend[$];
   logic [63:0] exp_q[$];
   int          n_checks = 0;
   int          n_pass = 0;
   int          ready_prob = 0;
   int          rsp_prob = 0;
   bit          inject_late = 1'b0;
   bit          rsp_real = 1'b0;
   bit          popped_now = 1'b0;
   logic [31:0] epoch = '0;
   logic [63:0] req_pc = RESET_PC;

   fetch_unit #(
      .RESET_PC(RESET_PC),
      .DEPTH(DEPTH),
      .MAX_OUTSTANDING(MAX_OUT),
      .NOP_INSTR(NOP_INSTR)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .stall_F(stall_F),
      .redirect_E(redirect_E),
      .redirect_pc_E(redirect_pc_E),
      .imem_req_valid(imem_req_valid),
      .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid),
      .imem_rsp_data(imem_rsp_data),
      .PC_F(PC_F),
      .Instr_F(Instr_F),
      .valid_F(valid_F)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: actual=time limit reached required=finish");
      $fatal(1, "watchdog");
   end

   // Memory contents: a simple function of the address; top byte is never 0xDE for small addresses.
   function automatic logic [31:0] word(input logic [63:0] a);
      return a[31:0] ^ 32'h5A00_0013;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_checks++;
      if (act === expv) begin
         n_pass++;
      end else begin
         $display("FAIL %s: actual=%h required=%h", name, act, expv);
      end
   endtask

   // imem model: drives ready/response after the edge, books handshakes before the next edge
   initial begin
      int stale;
      forever begin
         @(posedge clk);
         #2;
         imem_req_ready = ($urandom_range(1, 100) <= ready_prob);
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = $urandom;
         rsp_real       = 1'b0;
         if (inject_late) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = 32'hDEAD_BEEF;
            inject_late    = 1'b0;
         end else if (rst_n && pend.size() > 0 && $urandom_range(1, 100) <= rsp_prob) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = word(pend[0].addr);
            rsp_real       = 1'b1;
         end
         @(negedge clk);
         #1;
         if (!rst_n) begin
            pend.delete();
            exp_q.delete();
            req_pc = RESET_PC;
            epoch  = epoch + 1;
         end else begin
            if (redirect_E) begin
               chk("req_valid_in_redirect", imem_req_valid, 1'b0);
            end
            if (imem_req_valid && imem_req_ready) begin
               stale = 0;
               foreach (pend[i]) begin
                  if (pend[i].epoch != epoch) stale++;
               end
               chk("no_req_while_dropping", stale, 0);
               chk("req_addr", imem_req_addr, req_pc);
               chk("outstanding_bound", pend.size() < MAX_OUT, 1'b1);
               chk("credit_bound", (exp_q.size() + int'(popped_now)) < DEPTH, 1'b1);
               pend.push_back('{epoch: epoch, addr: req_pc});
               exp_q.push_back(req_pc);
               req_pc = req_pc + 64'd4;
            end
            if (imem_rsp_valid && rsp_real) begin
               void'(pend.pop_front());
            end
            if (redirect_E) begin
               epoch  = epoch + 1;
               exp_q.delete();
               req_pc = {redirect_pc_E[63:2], 2'b00};
            end
         end
      end
   end

   // monitor: compares every accepted IF output against the scoreboard head
   initial begin
      bit          hold_armed;
      logic [63:0] held_pc;
      logic [31:0] held_instr;
      logic [63:0] e;
      hold_armed = 1'b0;
      forever begin
         @(negedge clk);
         popped_now = 1'b0;
         if (!rst_n) begin
            hold_armed = 1'b0;
         end else begin
            if (hold_armed) begin
               chk("stall_hold_valid", valid_F, 1'b1);
               chk("stall_hold_pc", PC_F, held_pc);
               chk("stall_hold_instr", Instr_F, held_instr);
            end
            if (!valid_F) begin
               chk("idle_pc", PC_F, 64'h0);
               chk("idle_instr", Instr_F, NOP_INSTR);
            end else if (!stall_F) begin
               chk("sb_nonempty", exp_q.size() != 0, 1'b1);
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  chk("pc_f", PC_F, e);
                  chk("instr_f", Instr_F, word(e));
                  popped_now = 1'b1;
               end
            end
            hold_armed = valid_F && stall_F && !redirect_E;
            held_pc    = PC_F;
            held_instr = Instr_F;
         end
      end
   end

   task automatic wait_first_valid(input string nm, input logic [63:0] exp_pc);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (valid_F) begin
            seen = 1'b1;
            break;
         end
      end
      chk({nm, "_seen"}, seen, 1'b1);
      if (seen) chk(nm, PC_F, exp_pc);
   endtask

   task automatic do_redirect(input logic [63:0] target);
      @(posedge clk);
      #1;
      redirect_E    = 1'b1;
      redirect_pc_E = target;
      @(posedge clk);
      #1;
      redirect_E = 1'b0;
      rsp_prob   = 100;
   endtask

   // driver
   initial begin
      logic [31:0] r;
      repeat (3) @(negedge clk);
      chk("rst_valid_f", valid_F, 1'b0);
      chk("rst_pc_f", PC_F, 64'h0);
      chk("rst_instr_f", Instr_F, NOP_INSTR);
      chk("rst_req_valid", imem_req_valid, 1'b0);
      chk("rst_req_addr", imem_req_addr, RESET_PC);
      @(posedge clk);
      #3 rst_n = 1'b1;

      // memory not ready: request held, nothing presented
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("nrdy_req_valid", imem_req_valid, 1'b1);
         chk("nrdy_req_addr", imem_req_addr, RESET_PC);
         chk("nrdy_valid_f", valid_F, 1'b0);
         chk("nrdy_instr_f", Instr_F, NOP_INSTR);
      end

      // one-cycle memory, no stall: first word two cycles after the first handshake cycle
      @(posedge clk);
      #1;
      ready_prob = 100;
      rsp_prob   = 100;
      @(negedge clk);
      @(negedge clk);
      chk("lat_no_bypass", valid_F, 1'b0);
      @(negedge clk);
      chk("lat_first_valid", valid_F, 1'b1);
      chk("lat_first_pc", PC_F, RESET_PC);
      chk("lat_first_instr", Instr_F, word(RESET_PC));
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         chk("stream_valid", valid_F, 1'b1);
         chk("stream_pc", PC_F, RESET_PC + 64'(4 * k));
      end

      // stall for five cycles: requests stop when the credits run out
      @(posedge clk);
      #1;
      stall_F = 1'b1;
      repeat (5) @(negedge clk);
      chk("stall_req_stopped", imem_req_valid, 1'b0);
      chk("stall_valid_held", valid_F, 1'b1);
      @(posedge clk);
      #1;
      stall_F  = 1'b0;
      rsp_prob = 0;

      // redirect with two requests outstanding
      repeat (6) @(negedge clk);
      chk("two_outstanding", pend.size(), 2);
      do_redirect(64'h1000);
      @(negedge clk);
      chk("redir_next_addr", imem_req_addr, 64'h1000);
      chk("redir_dropping_no_req", imem_req_valid, 1'b0);
      wait_first_valid("redir_first_pc", 64'h1000);

      // misaligned target is word-aligned
      repeat (3) @(negedge clk);
      do_redirect(64'h1002);
      @(negedge clk);
      chk("misalign_next_addr", imem_req_addr, 64'h1000);
      wait_first_valid("misalign_first_pc", 64'h1000);

      // randomized traffic with stalls, back-pressure and redirects
      for (int blk = 0; blk < 15; blk++) begin
         int stall_prob;
         ready_prob = $urandom_range(20, 100);
         rsp_prob   = $urandom_range(20, 100);
         stall_prob = $urandom_range(0, 60);
         for (int c = 0; c < 200; c++) begin
            @(posedge clk);
            #1;
            stall_F    = ($urandom_range(1, 100) <= stall_prob);
            redirect_E = ($urandom_range(1, 40) == 1);
            r          = $urandom_range(0, 32'h000F_FFFF);
            redirect_pc_E = {32'h0, r};
         end
      end
      @(posedge clk);
      #1;
      redirect_E = 1'b0;
      stall_F    = 1'b0;
      ready_prob = 100;
      rsp_prob   = 100;
      repeat (10) @(negedge clk);

      // reset mid-stream, then a late response after release
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("midrst_valid_f", valid_F, 1'b0);
      chk("midrst_instr_f", Instr_F, NOP_INSTR);
      chk("midrst_req_valid", imem_req_valid, 1'b0);
      chk("midrst_req_addr", imem_req_addr, RESET_PC);
      @(posedge clk);
      #1;
      inject_late = 1'b1;
      #2 rst_n = 1'b1;
      @(negedge clk);
      chk("late_rsp_ignored", valid_F, 1'b0);
      wait_first_valid("restart_pc", RESET_PC);
      repeat (10) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch front end that produces the PC_F / Instr_F stream consumed by the IF/ID pipeline register. It is the writer side of that interface.
- Owns the fetch PC and issues in-order requests to instruction memory over a valid/ready request channel. Responses return in order and are buffered in a small queue.
- Honours decode stalls and EX-stage redirects (taken branch/jump). Stale in-flight responses are discarded after a redirect.

Parameters:
- RESET_PC, 64'h0, fetch address after reset.
- DEPTH, 4, instruction queue entries (power of two, 2..8).
- MAX_OUTSTANDING, 2, maximum accepted-but-unanswered imem requests (1..DEPTH).
- NOP_INSTR, 32'h00000013, value driven on Instr_F when no instruction is valid (addi x0,x0,0).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- stall_F  in  1  1 = IF/ID not accepting; hold current output.
- redirect_E  in  1  1 = taken branch/jump from EX; restart fetch.
- redirect_pc_E  in  64  redirect target.
- imem_req_valid  out  1  request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  64  request address.
- imem_rsp_valid  in  1  in-order response valid (always accepted).
- imem_rsp_data  in  32  response instruction word.
- PC_F  out  64  PC of presented instruction.
- Instr_F  out  32  presented instruction.
- valid_F  out  1  PC_F/Instr_F hold a real instruction.

Behaviour:
- Reset (async assert, sync release): pc_q=RESET_PC, queue empty, outstanding=0, drop_cnt=0.
- Outputs during reset: valid_F=0, PC_F=0, Instr_F=NOP_INSTR, imem_req_valid=0, imem_req_addr=RESET_PC.
- imem_req_addr = pc_q at all times.
- imem_req_valid = !redirect_E && drop_cnt==0 && outstanding<MAX_OUTSTANDING && (count+outstanding)<DEPTH.
- Request handshake (valid&&ready): pc_q += 4 (64-bit wrap); outstanding += 1.
- Response: outstanding -= 1. If drop_cnt>0, the response is discarded and drop_cnt -= 1; otherwise push {PC, data} into the queue.
- The PC for each outstanding request is kept in a small in-order PC FIFO of MAX_OUTSTANDING entries. Each response pairs with the head of that FIFO.
- Request and response in the same cycle: outstanding is unchanged.
- Output: queue empty -> valid_F=0, PC_F=0, Instr_F=NOP_INSTR. Otherwise valid_F=1 and PC_F/Instr_F are driven from the queue head (combinational read of registered storage).
- Pop when valid_F && !stall_F. With stall_F=1 the head is held stable.
- Latency: the response accepted at edge N is presented on valid_F at cycle N+1. There is no response-to-output bypass.
- Queue pointers wrap modulo DEPTH. Push and pop may occur in the same cycle. The credit check in the imem_req_valid equation ensures push never happens when the queue is full.
- Redirect (highest priority, that cycle):
  - Queue is flushed.
  - pc_q <= {redirect_pc_E[63:2],2'b00}.
  - drop_cnt <= outstanding minus any response arriving that same cycle (that response is dropped).
  - No request is issued in the redirect cycle.
  - Fetch from the target starts on the next cycle once drop_cnt==0.
- Redirect while stall_F=1: the flush still occurs, valid_F drops the next cycle.
- Back-to-back redirects: the later target wins and drop_cnt is recomputed each time.
- Reset mid-operation: all state is cleared immediately. Responses arriving after reset release with outstanding==0 are ignored.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- When defined, the block adds these ports:
  - perf_fetched (out, 64): increments on each pop.
  - perf_redirects (out, 64): increments on each redirect_E cycle.
  - perf_dropped (out, 32): increments on each discarded response.
- All three counters reset to 0, wrap on overflow, and have no effect on fetch behaviour.
- When undefined, these ports and registers do not exist.

Test Plan:
- Reset release, imem ready=1, 1-cycle response latency, stall_F=0 -> requests at 0x0,0x4,0x8,... Then valid_F rises with PC_F=0x0 and Instr_F=first word, followed by consecutive PCs every cycle.
- stall_F=1 held 5 cycles with imem ready -> requests stop once count+outstanding=4 (DEPTH). PC_F is held and no instruction is lost or duplicated after release.
- redirect_E=1 with redirect_pc_E=0x1000 while 2 requests are outstanding -> both responses are dropped. The next cycle shows imem_req_addr=0x1000, and the first valid PC_F after the redirect is 0x1000.
- redirect_pc_E=0x1002 -> fetch resumes at 0x1000.
- imem_req_ready=0 for 10 cycles -> imem_req_valid stays 1 with a stable addr, valid_F=0, Instr_F=0x00000013.
- Assert rst_n=0 mid-stream with a response arriving after release -> valid_F=0 immediately, the late response is ignored, and fetch restarts at RESET_PC. With FETCH_PERF_CNT_EN, the counters read 0.
